// File: rtl/fifo_wr_packer_if.sv
// Byte-in / word-out handshake bundle between an upstream byte source, the packer and a FIFO write port.
// Latency: none, this is a wiring bundle only.
// Backpressure: in_ready flows back to the source; fifo_full flows back from the FIFO.
interface fifo_wr_packer_if #(
  parameter int IN_WIDTH = 8
);
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  fifo_full;
  logic [2*IN_WIDTH-1:0] din_a;
  logic                  wen_a;
  logic                  busy;

  // Environment side: supplies bytes and the FIFO full flag.
  modport master (
    output in_data, in_valid, in_last, fifo_full,
    input  in_ready, din_a, wen_a, busy
  );

  // Packer side.
  modport slave (
    input  in_data, in_valid, in_last, fifo_full,
    output in_ready, din_a, wen_a, busy
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs pairs of bytes (low byte first) into 2-byte FIFO write words; odd frame tails get PAD_VALUE on top.
// Latency: wen_a rises 1 clk_a cycle after the completing byte is accepted; sustains 1 word per 2 cycles.
// Backpressure: a pending word holds din_a/wen_a while fifo_full; in_ready drops only while the word is stuck.
// Optional statistics: define FIFO_WR_PACKER_STATS_EN to add the 16-bit saturating word_count output.
module fifo_wr_packer #(
  parameter int                  IN_WIDTH  = 8,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE = 8'h00
) (
  input  logic              clk_a,
  input  logic              rst,
  fifo_wr_packer_if.slave   bus
`ifdef FIFO_WR_PACKER_STATS_EN
  ,
  output logic [15:0]       word_count
`endif
);

  localparam int OUT_WIDTH = 2 * IN_WIDTH;

  // LOW: nothing held, HIGH: low byte held, WRITE: full word presented to the FIFO.
  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_HIGH  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t               r_state;
  logic [OUT_WIDTH-1:0] r_din;
  logic                 r_wen;
  logic                 r_busy;

  logic w_wr_acc;
  logic w_in_rdy;
  logic w_in_acc;

  // A write completes on an edge where the request is up and the FIFO is not full.
  assign w_wr_acc = r_wen & ~bus.fifo_full;

  // While a word is pending, a byte may only enter on the same edge the word leaves,
  // so in WRITE an accepted byte always implies an accepted write.
  assign w_in_rdy = (r_state != ST_WRITE) | w_wr_acc;
  assign w_in_acc = bus.in_valid & w_in_rdy;

  assign bus.in_ready = w_in_rdy;
  assign bus.din_a    = r_din;
  assign bus.wen_a    = r_wen;
  assign bus.busy     = r_busy;

  // Packing FSM: state, word register, write request and busy all update together.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_din   <= '0;
      r_wen   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_in_acc && (r_state == ST_HIGH)) begin
      // Second byte completes the word; in_last has nothing more to do here.
      r_din[OUT_WIDTH-1:IN_WIDTH] <= bus.in_data;
      r_state                     <= ST_WRITE;
      r_wen                       <= 1'b1;
      r_busy                      <= 1'b1;
    end else if (w_in_acc) begin
      // First byte of a word, arriving in LOW or back-to-back as the previous word leaves WRITE.
      r_din[IN_WIDTH-1:0] <= bus.in_data;
      r_busy              <= 1'b1;
      if (bus.in_last) begin
        r_din[OUT_WIDTH-1:IN_WIDTH] <= PAD_VALUE;
        r_state                     <= ST_WRITE;
        r_wen                       <= 1'b1;
      end else begin
        r_state <= ST_HIGH;
        r_wen   <= 1'b0;
      end
    end else if (w_wr_acc) begin
      // Word drained with no new byte behind it.
      r_state <= ST_LOW;
      r_wen   <= 1'b0;
      r_busy  <= 1'b0;
    end
  end

`ifdef FIFO_WR_PACKER_STATS_EN
  logic [15:0] r_word_count;

  // Count completed FIFO writes, sticking at all-ones rather than wrapping.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      r_word_count <= 16'h0000;
    end else if (w_wr_acc && (r_word_count != 16'hFFFF)) begin
      r_word_count <= r_word_count + 16'h0001;
    end
  end

  assign word_count = r_word_count;
`else
  // No statistics port or counter in this build.
`endif

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, meaning the input byte width.
REQ-002 SHALL have parameter PAD_VALUE, default 8'h00, meaning the fill byte for an odd-length frame tail.
REQ-003 SHALL derive OUT_WIDTH = 2*IN_WIDTH, so the default is 16 and matches the FIFO write port.
REQ-004 SHALL have port clk_a, input, 1 bit: write-domain clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high; clock clk_a.
REQ-006 SHALL have port in_data, input, IN_WIDTH bits: upstream byte.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_last, input, 1 bit: the byte is the final byte of its frame.
REQ-009 SHALL have port in_ready, output, 1 bit: packer accepts a byte this cycle.
REQ-010 SHALL have port fifo_full, input, 1 bit: downstream FIFO full flag, which may depend combinationally on wen_a.
REQ-011 SHALL have port din_a, output, OUT_WIDTH bits: packed word to the FIFO.
REQ-012 SHALL have port wen_a, output, 1 bit: FIFO write request.
REQ-013 SHALL have port busy, output, 1 bit: a partial or pending word is held.

Function
REQ-014 SHALL accept a byte on a clk_a edge iff in_valid && in_ready, and SHALL define a write as accepted on an edge iff wen_a && !fifo_full.
REQ-015 SHALL implement states LOW (no byte held), HIGH (low byte held) and WRITE (word pending); wen_a SHALL be 1 exactly in WRITE and SHALL be a registered output with no combinational path from fifo_full.
REQ-016 SHALL drive in_ready = (state != WRITE) || (wen_a && !fifo_full), giving single-edge turnaround when a write completes.
REQ-017 LOW: on an accepted byte it SHALL store it as din_a[IN_WIDTH-1:0]; if in_last, set the upper half to PAD_VALUE and go to WRITE, else go to HIGH.
REQ-018 HIGH: on an accepted byte it SHALL store it as din_a[OUT_WIDTH-1:IN_WIDTH] and go to WRITE, with in_last carrying no further effect.
REQ-019 WRITE: din_a and wen_a SHALL hold stable while fifo_full=1, and no byte SHALL be lost or duplicated.
REQ-020 WRITE with the write accepted and no byte accepted: SHALL go to LOW.
REQ-021 WRITE with the write accepted and a byte accepted on the same edge: SHALL apply the REQ-017 action to that byte.
REQ-022 SHALL give latency of 1 clk_a cycle from acceptance of the completing byte to wen_a=1, and SHALL sustain 1 word per 2 cycles at full rate.
REQ-023 SHALL drive busy = (state != LOW).

Reset
REQ-024 rst=1 on an edge SHALL force state LOW, wen_a=0, din_a=0, busy=0, and in_ready=1 once rst deasserts.
REQ-025 rst mid-operation SHALL discard any held byte or pending word without a write; rst SHALL override all simultaneous events.

Configuration
REQ-026 With macro FIFO_WR_PACKER_STATS_EN defined, the block SHALL add output word_count, 16 bits, reset to 0, incremented by 1 per accepted write, saturating at 16'hFFFF.
REQ-027 Without FIFO_WR_PACKER_STATS_EN, port word_count and its counter SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-028 Bytes 8'h11, 8'h22 (last) with fifo_full=0 -> a single wen_a pulse with din_a=16'h2211 one cycle after 8'h22 is accepted.
REQ-029 Single byte 8'hA5 with in_last=1 -> din_a=16'h00A5, wen_a for 1 cycle, then state LOW.
REQ-030 Word 16'h4433 pending with fifo_full=1 for 5 cycles -> wen_a=1 and din_a=16'h4433 held throughout, in_ready=0, and exactly one write after full drops.
REQ-031 Continuous stream 8'h01..8'h08 with in_valid=1 -> words 16'h0201, 16'h0403, 16'h0605, 16'h0807 with no gaps beyond 1 word per 2 cycles.
REQ-032 rst asserted while HIGH holds 8'h77 -> no write occurs, busy=0, and the next bytes 8'h01, 8'h02 yield 16'h0201.
REQ-033 With FIFO_WR_PACKER_STATS_EN defined, 3 accepted writes -> word_count=3; after rst -> word_count=0.
